// File: rtl/step_dir_pulse_gen_if.sv
// Move-command channel for step_dir_pulse_gen: valid/ready handshake carrying dir, step count, period and pulse width.
// Every command field is qualified by cmd_valid; the slave raises cmd_ready only when it can take a new move.
interface step_dir_pulse_gen_if #(
    parameter int COUNT_W  = 32,
    parameter int PERIOD_W = 24,
    parameter int PULSE_W  = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_dir;
    logic [COUNT_W-1:0]  cmd_steps;
    logic [PERIOD_W-1:0] cmd_period;
    logic [PULSE_W-1:0]  cmd_pulse;

    modport master (
        output cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_pulse,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_steps, cmd_period, cmd_pulse,
        output cmd_ready
    );
endinterface

// File: rtl/step_dir_pulse_gen.sv
// Step/dir pulse train generator: first step DIR_SETUP+1 cycles after accept, one command at a time (cmd_ready low while busy).
// Define STEP_POS_COUNTER_EN to add the signed position counter and its port.
module step_dir_pulse_gen #(
    parameter int COUNT_W   = 32,
    parameter int PERIOD_W  = 24,
    parameter int PULSE_W   = 8,
    parameter int DIR_SETUP = 16
`ifdef STEP_POS_COUNTER_EN
    ,
    parameter int POS_W     = 32
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    step_dir_pulse_gen_if.slave  cmd,
    input  logic                 abort,
    output logic                 step,
    output logic                 dir,
    output logic                 busy,
    output logic                 done,
    output logic [COUNT_W-1:0]   steps_left
`ifdef STEP_POS_COUNTER_EN
    ,
    output logic [POS_W-1:0]     position
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;
    localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(DIR_SETUP - 1);

    logic [1:0]          state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per_q;
    logic [PULSE_W-1:0]  pw_q;
    logic                abort_pend;
    logic                ready_q;

    logic [PULSE_W-1:0]  pw_c;
    logic [PERIOD_W-1:0] per_c;
    logic [PERIOD_W-1:0] low_last;
    logic                accept;
    logic                go_high;
    logic                go_idle;

    // abort gates the registered ready so a same-cycle abort always beats a pending command
    assign cmd.cmd_ready = ready_q & ~abort;

    always_comb begin
        pw_c     = (cmd.cmd_pulse == '0) ? PULSE_W'(1) : cmd.cmd_pulse;
        per_c    = (cmd.cmd_period > PERIOD_W'(pw_c)) ? cmd.cmd_period
                                                      : PERIOD_W'(pw_c) + PERIOD_W'(1);
        low_last = per_q - PERIOD_W'(pw_q) - PERIOD_W'(1);
        accept   = cmd.cmd_valid & ready_q & ~abort;
        go_high  = (cnt == '0) && !abort &&
                   ((state == S_SETUP) || (state == S_LOW && steps_left != '0));
        go_idle  = (state == S_SETUP && abort) ||
                   (state == S_HIGH && cnt == '0 && (abort || abort_pend)) ||
                   (state == S_LOW && (abort || (cnt == '0 && steps_left == '0)));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            step       <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ready_q    <= 1'b0;
            steps_left <= '0;
            cnt        <= '0;
            per_q      <= '0;
            pw_q       <= '0;
            abort_pend <= 1'b0;
`ifdef STEP_POS_COUNTER_EN
            position   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (go_idle) begin
                state      <= S_IDLE;
                step       <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                ready_q    <= 1'b1;
                abort_pend <= 1'b0;
            end else if (go_high) begin
                state      <= S_HIGH;
                step       <= 1'b1;
                steps_left <= steps_left - COUNT_W'(1);
                cnt        <= PERIOD_W'(pw_q) - PERIOD_W'(1);
                abort_pend <= 1'b0;
`ifdef STEP_POS_COUNTER_EN
                position   <= dir ? position + POS_W'(1) : position - POS_W'(1);
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        ready_q    <= 1'b1;
                        abort_pend <= 1'b0;
                        if (accept) begin
                            pw_q  <= pw_c;
                            per_q <= per_c;
                            if (cmd.cmd_steps == '0) begin
                                done <= 1'b1;
                            end else begin
                                dir        <= cmd.cmd_dir;
                                busy       <= 1'b1;
                                ready_q    <= 1'b0;
                                steps_left <= cmd.cmd_steps;
                                cnt        <= SETUP_LAST;
                                state      <= S_SETUP;
                            end
                        end
                    end
                    S_HIGH: begin
                        if (cnt == '0) begin
                            step  <= 1'b0;
                            state <= S_LOW;
                            cnt   <= low_last;
                        end else begin
                            cnt        <= cnt - PERIOD_W'(1);
                            abort_pend <= abort_pend | abort;
                        end
                    end
                    default: cnt <= cnt - PERIOD_W'(1);
                endcase
            end
        end
    end
endmodule

// File: tb/tb_step_dir_pulse_gen.sv
// Bench for step_dir_pulse_gen: directed plus random moves, events predicted from pulse-train arithmetic and scoreboarded.
module tb_step_dir_pulse_gen;
    localparam int DS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort = 1'b0;
    logic        step, dir, busy, done;
    logic [31:0] steps_left;
`ifdef STEP_POS_COUNTER_EN
    logic [31:0] position;
`endif

    step_dir_pulse_gen_if #(.COUNT_W(32), .PERIOD_W(24), .PULSE_W(8)) cif();

    step_dir_pulse_gen #(
        .COUNT_W(32), .PERIOD_W(24), .PULSE_W(8), .DIR_SETUP(DS)
    ) dut (
        .CLK(clk), .RST(rst), .cmd(cif), .abort(abort),
        .step(step), .dir(dir), .busy(busy), .done(done),
        .steps_left(steps_left)
`ifdef STEP_POS_COUNTER_EN
        , .position(position)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_done;
        int          at;
        bit          d;
        int          sl;
        int          pw;
        logic [31:0] pos;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] pos_model = '0;
    int          busy_lo = 1, busy_hi = 0;
    bit          mon_en = 1'b0;
    bit          step_prev = 1'b0;
    int          hi_cnt = 0, exp_pw = 0;
    int          bp_expect = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en) begin
            chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
            chk("ready_while_busy", busy & cif.cmd_ready, 0);
            if (step && !step_prev) begin
                if (evq.size() == 0) chk("unexpected_step", 1, 0);
                else begin
                    e = evq.pop_front();
                    chk("step_kind", e.is_done, 0);
                    chk("step_cycle", cyc, e.at);
                    chk("step_dir", dir, e.d);
                    chk("step_left", steps_left, e.sl);
`ifdef STEP_POS_COUNTER_EN
                    chk("position", position, e.pos);
`endif
                    exp_pw = e.pw;
                end
                hi_cnt = 1;
            end else if (step) begin
                hi_cnt++;
            end else if (step_prev) begin
                chk("pulse_width", hi_cnt, exp_pw);
            end
            if (done) begin
                if (evq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = evq.pop_front();
                    chk("done_kind", e.is_done, 1);
                    chk("done_cycle", cyc, e.at);
                    if (e.sl >= 0) chk("done_left", steps_left, e.sl);
                end
            end
        end
        step_prev = step;
    end

    task automatic run_cmd(input bit d, input int steps, input int period, input int pulse,
                           input int abort_off, input bit bp);
        int n, t, pw, per, r0, done_at, np, c, k, off;
        ev_t e;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b1;
        cif.cmd_dir = d;
        cif.cmd_steps = 32'(steps);
        cif.cmd_period = 24'(period);
        cif.cmd_pulse = 8'(pulse);
        n = 0;
        @(negedge clk);
        while (!(cif.cmd_valid && cif.cmd_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("accept_timeout", 0, 1);
            cif.cmd_valid = 1'b0;
            return;
        end
        t = cyc;
        if (bp_expect >= 0) begin
            chk("bp_accept_cycle", t, bp_expect);
            bp_expect = -1;
        end
        pw  = (pulse == 0) ? 1 : pulse;
        per = (period > pw) ? period : pw + 1;
        if (steps == 0) begin
            e.is_done = 1; e.at = t + 1; e.d = d; e.sl = -1; e.pw = 0; e.pos = pos_model;
            evq.push_back(e);
            busy_lo = 1; busy_hi = 0;
            done_at = t + 1;
        end else begin
            r0 = t + 1 + DS;
            np = steps;
            done_at = r0 + steps * per;
            if (abort_off >= 0) begin
                c = t + 1 + abort_off;
                if (c < r0) begin
                    np = 0;
                    done_at = c + 1;
                end else if (c < done_at) begin
                    k = (c - r0) / per;
                    off = (c - r0) % per;
                    np = k + 1;
                    done_at = (off < pw) ? r0 + k * per + pw : c + 1;
                end
            end
            for (int i = 0; i < np; i++) begin
                pos_model = d ? pos_model + 32'd1 : pos_model - 32'd1;
                e.is_done = 0; e.at = r0 + i * per; e.d = d; e.sl = steps - i - 1;
                e.pw = pw; e.pos = pos_model;
                evq.push_back(e);
            end
            e.is_done = 1; e.at = done_at; e.d = d; e.sl = steps - np; e.pw = 0; e.pos = pos_model;
            evq.push_back(e);
            busy_lo = t + 1;
            busy_hi = done_at - 1;
        end
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        if (abort_off >= 0) begin
            c = t + 1 + abort_off;
            while (cyc < c) begin
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        if (bp) begin
            bp_expect = done_at;
        end else begin
            n = 0;
            while ((cyc <= done_at + 1 || evq.size() != 0) && n < 3000) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 3000) chk("done_timeout", 0, 1);
        end
    endtask

    task automatic idle_abort();
        @(posedge clk); #1;
        abort = 1'b1;
        cif.cmd_valid = 1'b1; cif.cmd_dir = 1'b1; cif.cmd_steps = 32'd3;
        cif.cmd_period = 24'd5; cif.cmd_pulse = 8'd2;
        repeat (4) begin
            @(negedge clk);
            chk("ready_under_abort", cif.cmd_ready, 0);
        end
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", cif.cmd_ready, 1);
        repeat (DS + 4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_left"}, steps_left, 0);
        chk({tag, "_ready"}, cif.cmd_ready, 0);
`ifdef STEP_POS_COUNTER_EN
        chk({tag, "_pos"}, position, 0);
`endif
    endtask

    task automatic mid_move_reset();
        int n;
        mon_en = 1'b0;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b1; cif.cmd_dir = 1'b1; cif.cmd_steps = 32'd20;
        cif.cmd_period = 24'd10; cif.cmd_pulse = 8'd3;
        n = 0;
        @(negedge clk);
        while (!cif.cmd_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!step && n < 200) begin @(negedge clk); n++; end
        chk("mid_move_step_seen", step, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_hold", cif.cmd_ready, 0);
        @(negedge clk);
        chk("midrst_ready_up", cif.cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        evq.delete();
        pos_model = '0;
        busy_lo = 1; busy_hi = 0;
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, s, p, w, ab, bp;
        cif.cmd_valid = 1'b0; cif.cmd_dir = 1'b0; cif.cmd_steps = '0;
        cif.cmd_period = '0; cif.cmd_pulse = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", cif.cmd_ready, 1);
        mon_en = 1'b1;

        run_cmd(1, 4, 10, 3, -1, 0);
        run_cmd(1, 2, 2, 5, -1, 0);
        run_cmd(0, 3, 4, 0, -1, 0);
        run_cmd(1, 0, 7, 2, -1, 0);
        run_cmd(1, 5, 8, 3, DS + 1, 0);
        run_cmd(0, 5, 8, 3, DS + 5, 0);
        run_cmd(1, 3, 6, 2, 3, 0);
        idle_abort();
        run_cmd(0, 3, 6, 2, -1, 0);
        run_cmd(1, 2, 9, 4, -1, 1);
        run_cmd(0, 2, 5, 1, -1, 0);
        mid_move_reset();

        for (int i = 0; i < 30; i++) begin
            d  = $urandom_range(0, 1);
            s  = $urandom_range(0, 5);
            p  = $urandom_range(0, 20);
            w  = $urandom_range(0, 10);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, DS + s * 21 + 4) : -1;
            bp = (s > 0 && ab < 0 && i < 29 && $urandom_range(0, 3) == 0) ? 1 : 0;
            run_cmd(d[0], s, p, w, ab, bp[0]);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
